// File: rtl/set_assoc_cache_controller_pkg.sv
// cache_pkg: shared types and width helpers for the set-associative cache
// controller and its tree-PLRU sub-module.
//   state_t  : controller FSM states (IDLE, COMPARE, WRITE_BACK, ALLOCATE)
//   offset_w : byte-offset bits in a line
//   index_w  : set-index bits
//   tag_w    : tag bits (remaining address MSBs)
//   way_w    : bits needed to name a way (at least 1)
//   plru_w   : tree-PLRU bits per set (at least 1 so storage never has width 0)
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    COMPARE    = 2'd1,
    WRITE_BACK = 2'd2,
    ALLOCATE   = 2'd3
  } state_t;

  function automatic int offset_w(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic int index_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int line_w, input int num_sets);
    return addr_w - offset_w(line_w) - index_w(num_sets);
  endfunction

  function automatic int way_w(input int num_ways);
    return (num_ways > 1) ? $clog2(num_ways) : 1;
  endfunction

  function automatic int plru_w(input int num_ways);
    return (num_ways > 1) ? num_ways - 1 : 1;
  endfunction

endpackage

// File: rtl/set_assoc_cache_controller_plru.sv
// cache_plru: per-set tree-PLRU state.
//   clock, reset_n : rising-edge clock, synchronous active-low reset (clears all trees)
//   i_upd_en       : record an access to way i_upd_way of set i_upd_set
//   i_rd_set       : set whose victim is requested
//   o_victim       : pseudo-least-recently-used way of i_rd_set (combinational)
// Tree bits point towards the victim side; an access flips the bits on its
// path to point away from the accessed way. With one way there is no state.
module cache_plru
  import cache_pkg::*;
#(
  parameter int NUM_SETS = 512,
  parameter int NUM_WAYS = 2,
  localparam int IDX_W = index_w(NUM_SETS),
  localparam int WAY_W = way_w(NUM_WAYS)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_upd_en,
  input  logic [IDX_W-1:0] i_upd_set,
  input  logic [WAY_W-1:0] i_upd_way,
  input  logic [IDX_W-1:0] i_rd_set,
  output logic [WAY_W-1:0] o_victim
);

  if (NUM_WAYS == 1) begin : g_dm
    logic w_unused_plru;
    assign w_unused_plru = ^{clock, reset_n, i_upd_en, i_upd_set, i_upd_way, i_rd_set};
    assign o_victim = '0;
  end else begin : g_tree
    localparam int PW = plru_w(NUM_WAYS);
    logic [PW-1:0] r_tree [NUM_SETS];
    logic [PW-1:0] w_next;
    logic [PW-1:0] w_rd;

    assign w_rd = r_tree[i_rd_set];

    if (NUM_WAYS == 2) begin : g_w2
      assign w_next   = ~i_upd_way;
      assign o_victim = w_rd;
    end else begin : g_w4
      logic [PW-1:0] w_cur;
      assign w_cur = r_tree[i_upd_set];
      // bit0 selects the half, bit1/bit2 select within left/right half
      always_comb begin
        w_next    = w_cur;
        w_next[0] = ~i_upd_way[1];
        if (i_upd_way[1]) w_next[2] = ~i_upd_way[0];
        else              w_next[1] = ~i_upd_way[0];
      end
      assign o_victim = {w_rd[0], (w_rd[0] ? w_rd[2] : w_rd[1])};
    end

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        for (int s = 0; s < NUM_SETS; s++) r_tree[s] <= '0;
      end else if (i_upd_en) begin
        r_tree[i_upd_set] <= w_next;
      end
    end
  end

endmodule

// File: rtl/set_assoc_cache_controller.sv
// set_assoc_cache_controller: N-way set-associative write-back cache between a
// CPU request port and memory, with tree-PLRU replacement and no fetch on a
// full-line write miss.
//   clock, reset_n    : rising-edge clock, synchronous active-low reset
//   cpu_req_*         : CPU request (addr/datain/rw/valid); accepted on valid && cache_ready
//   cache_ready       : high only while IDLE
//   cpu_req_dataout   : read data, valid while cpu_resp_valid
//   cpu_resp_valid    : one-cycle completion pulse for reads and writes
//   mem_req_*         : memory request (addr/dataout/rw/valid, datain/ready)
//   hit/miss/wb_count : statistics, live only when CACHE_STATS_EN is defined
//   dbg_state         : current FSM state
// Handshake: both ports transfer on the rising edge where valid && ready. The
// memory request is held stable while valid && !ready; ready without valid is
// ignored, and a CPU request while cache_ready is low is dropped.
module set_assoc_cache_controller
  import cache_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 128,
  parameter int NUM_SETS = 512,
  parameter int NUM_WAYS = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [LINE_W-1:0] cpu_req_datain,
  input  logic              cpu_req_rw,
  input  logic              cpu_req_valid,
  output logic              cache_ready,
  output logic [LINE_W-1:0] cpu_req_dataout,
  output logic              cpu_resp_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0] mem_req_dataout,
  output logic              mem_req_rw,
  output logic              mem_req_valid,
  input  logic [LINE_W-1:0] mem_req_datain,
  input  logic              mem_req_ready,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
  output logic [31:0]       wb_count,
  output state_t            dbg_state
);

  localparam int OFF_W = offset_w(LINE_W);
  localparam int IDX_W = index_w(NUM_SETS);
  localparam int TAG_W = tag_w(ADDR_W, LINE_W, NUM_SETS);
  localparam int WAY_W = way_w(NUM_WAYS);

  state_t              r_state;
  logic [TAG_W-1:0]    r_req_tag;
  logic [IDX_W-1:0]    r_req_idx;
  logic [LINE_W-1:0]   r_req_data;
  logic                r_req_rw;
  logic [WAY_W-1:0]    r_victim;

  logic [NUM_WAYS-1:0] r_valid    [NUM_SETS];
  logic [NUM_WAYS-1:0] r_dirty    [NUM_SETS];
  logic [TAG_W-1:0]    r_tag_arr  [NUM_WAYS][NUM_SETS];
  logic [LINE_W-1:0]   r_data_arr [NUM_WAYS][NUM_SETS];

  logic                r_resp_valid;
  logic [LINE_W-1:0]   r_dataout;
  logic                r_mem_valid;
  logic                r_mem_rw;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [LINE_W-1:0]   r_mem_dataout;

  // Offset bits select bytes inside a line and play no part in lookup.
  logic w_unused_offset;
  assign w_unused_offset = ^cpu_req_addr[OFF_W-1:0];

  // Lookup of the latched request against its set
  logic [NUM_WAYS-1:0] w_set_valid, w_set_dirty, w_match;
  logic [WAY_W-1:0]    w_hit_way, w_inv_way, w_plru_way, w_victim;
  logic                w_hit, w_victim_dirty;

  assign w_set_valid = r_valid[r_req_idx];
  assign w_set_dirty = r_dirty[r_req_idx];

  always_comb begin
    w_hit_way = '0;
    w_inv_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      w_match[w] = w_set_valid[w] && (r_tag_arr[w][r_req_idx] == r_req_tag);
      if (w_match[w]) w_hit_way = WAY_W'(w);
    end
    // descending scan leaves the lowest-index invalid way selected
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!w_set_valid[w]) w_inv_way = WAY_W'(w);
    end
  end

  assign w_hit          = |w_match;
  assign w_victim       = (&w_set_valid) ? w_plru_way : w_inv_way;
  assign w_victim_dirty = w_set_valid[w_victim] && w_set_dirty[w_victim];

  logic w_accept, w_hit_ev, w_miss_ev, w_wb_done, w_alloc_done;
  assign w_accept     = (r_state == IDLE) && cpu_req_valid;
  assign w_hit_ev     = (r_state == COMPARE) && w_hit;
  assign w_miss_ev    = (r_state == COMPARE) && !w_hit;
  assign w_wb_done    = (r_state == WRITE_BACK) && r_mem_valid && mem_req_ready;
  assign w_alloc_done = (r_state == ALLOCATE) && r_mem_valid && mem_req_ready;

  // Single line-write port: write hit, installs of write misses, refill.
  logic              w_we, w_we_dirty;
  logic [WAY_W-1:0]  w_we_way;
  logic [LINE_W-1:0] w_we_data;

  always_comb begin
    w_we       = 1'b0;
    w_we_way   = r_victim;
    w_we_data  = r_req_data;
    w_we_dirty = 1'b1;
    if (w_hit_ev && r_req_rw) begin
      w_we     = 1'b1;
      w_we_way = w_hit_way;
    end else if (w_miss_ev && !w_victim_dirty && r_req_rw) begin
      w_we     = 1'b1;
      w_we_way = w_victim;
    end else if (w_wb_done && r_req_rw) begin
      w_we     = 1'b1;
    end else if (w_alloc_done) begin
      w_we       = 1'b1;
      w_we_data  = mem_req_datain;
      w_we_dirty = 1'b0;
    end
  end

  cache_plru #(
    .NUM_SETS (NUM_SETS),
    .NUM_WAYS (NUM_WAYS)
  ) u_plru (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_upd_en  (w_hit_ev || w_we),
    .i_upd_set (r_req_idx),
    .i_upd_way (w_hit_ev ? w_hit_way : w_we_way),
    .i_rd_set  (r_req_idx),
    .o_victim  (w_plru_way)
  );

  // Data and tag arrays carry no reset; valid bits qualify them.
  always_ff @(posedge clock) begin
    if (reset_n && w_we) begin
      r_data_arr[w_we_way][r_req_idx] <= w_we_data;
      r_tag_arr[w_we_way][r_req_idx]  <= r_req_tag;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_req_tag     <= '0;
      r_req_idx     <= '0;
      r_req_data    <= '0;
      r_req_rw      <= 1'b0;
      r_victim      <= '0;
      r_resp_valid  <= 1'b0;
      r_dataout     <= '0;
      r_mem_valid   <= 1'b0;
      r_mem_rw      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_dataout <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
      end
    end else begin
      r_resp_valid <= 1'b0;
      if (w_we) begin
        r_valid[r_req_idx][w_we_way] <= 1'b1;
        r_dirty[r_req_idx][w_we_way] <= w_we_dirty;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_req_tag  <= cpu_req_addr[ADDR_W-1 -: TAG_W];
            r_req_idx  <= cpu_req_addr[OFF_W +: IDX_W];
            r_req_data <= cpu_req_datain;
            r_req_rw   <= cpu_req_rw;
            r_state    <= COMPARE;
          end
        end
        COMPARE: begin
          if (w_hit) begin
            r_resp_valid <= 1'b1;
            if (!r_req_rw) r_dataout <= r_data_arr[w_hit_way][r_req_idx];
            r_state <= IDLE;
          end else begin
            r_victim <= w_victim;
            if (w_victim_dirty) begin
              r_mem_valid   <= 1'b1;
              r_mem_rw      <= 1'b1;
              r_mem_addr    <= {r_tag_arr[w_victim][r_req_idx], r_req_idx, {OFF_W{1'b0}}};
              r_mem_dataout <= r_data_arr[w_victim][r_req_idx];
              r_state       <= WRITE_BACK;
            end else if (!r_req_rw) begin
              r_mem_valid <= 1'b1;
              r_mem_rw    <= 1'b0;
              r_mem_addr  <= {r_req_tag, r_req_idx, {OFF_W{1'b0}}};
              r_state     <= ALLOCATE;
            end else begin
              // full-line write miss: installed without fetching the line
              r_resp_valid <= 1'b1;
              r_state      <= IDLE;
            end
          end
        end
        WRITE_BACK: begin
          if (mem_req_ready) begin
            if (r_req_rw) begin
              r_mem_valid  <= 1'b0;
              r_resp_valid <= 1'b1;
              r_state      <= IDLE;
            end else begin
              // valid stays high: the refill request follows directly
              r_mem_rw   <= 1'b0;
              r_mem_addr <= {r_req_tag, r_req_idx, {OFF_W{1'b0}}};
              r_state    <= ALLOCATE;
            end
          end
        end
        ALLOCATE: begin
          if (mem_req_ready) begin
            r_mem_valid <= 1'b0;
            r_state     <= COMPARE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cache_ready     = (r_state == IDLE);
  assign cpu_resp_valid  = r_resp_valid;
  assign cpu_req_dataout = r_dataout;
  assign mem_req_valid   = r_mem_valid;
  assign mem_req_rw      = r_mem_rw;
  assign mem_req_addr    = r_mem_addr;
  assign mem_req_dataout = r_mem_dataout;
  assign dbg_state       = r_state;

`ifdef CACHE_STATS_EN
  logic [31:0] r_hit_cnt, r_miss_cnt, r_wb_cnt;
  logic        r_refill;  // COMPARE is the re-lookup after a refill

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_wb_cnt   <= '0;
      r_refill   <= 1'b0;
    end else begin
      if (w_alloc_done)  r_refill <= 1'b1;
      else if (w_accept) r_refill <= 1'b0;
      if (w_hit_ev && !r_refill && (r_hit_cnt != '1)) r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (w_miss_ev && (r_miss_cnt != '1))            r_miss_cnt <= r_miss_cnt + 32'd1;
      if (w_wb_done && (r_wb_cnt != '1))              r_wb_cnt   <= r_wb_cnt + 32'd1;
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
  assign wb_count   = r_wb_cnt;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
  assign wb_count   = '0;
`endif

endmodule

// File: tb/tb_set_assoc_cache_controller.sv
// Testbench for set_assoc_cache_controller (2 ways, 512 sets, 128-bit lines).
// Honours CACHE_STATS_EN: expected counters are zero when it is undefined.
module tb_set_assoc_cache_controller;
  import cache_pkg::*;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [31:0]   cpu_req_addr;
  logic [127:0]  cpu_req_datain;
  logic          cpu_req_rw;
  logic          cpu_req_valid;
  logic          cache_ready;
  logic [127:0]  cpu_req_dataout;
  logic          cpu_resp_valid;
  logic [31:0]   mem_req_addr;
  logic [127:0]  mem_req_dataout;
  logic          mem_req_rw;
  logic          mem_req_valid;
  logic [127:0]  mem_req_datain;
  logic          mem_req_ready;
  logic [31:0]   hit_count, miss_count, wb_count;
  state_t        dbg_state;

  set_assoc_cache_controller dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req_addr(cpu_req_addr), .cpu_req_datain(cpu_req_datain),
    .cpu_req_rw(cpu_req_rw), .cpu_req_valid(cpu_req_valid),
    .cache_ready(cache_ready), .cpu_req_dataout(cpu_req_dataout),
    .cpu_resp_valid(cpu_resp_valid),
    .mem_req_addr(mem_req_addr), .mem_req_dataout(mem_req_dataout),
    .mem_req_rw(mem_req_rw), .mem_req_valid(mem_req_valid),
    .mem_req_datain(mem_req_datain), .mem_req_ready(mem_req_ready),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic         rw;
    logic [127:0] data;
    int           acc;
    int           lat;
    logic [31:0]  hits, miss, wb;
  } exp_t;
  typedef struct packed {
    logic         rw;
    logic [31:0]  addr;
    logic [127:0] data;
  } mexp_t;

  exp_t  exp_q[$];
  mexp_t mexp_q[$];

  logic [127:0] ref_mem [logic [31:0]];  // memory as the model sees it
  logic [127:0] rsp_mem [logic [31:0]];  // memory as the responder holds it
  logic         m_val   [512][2];
  logic         m_dirty [512][2];
  logic [18:0]  m_tag   [512][2];
  logic [127:0] m_data  [512][2];
  int unsigned  m_stamp [512][2];
  int unsigned  m_time, m_hits, m_miss, m_wb;
  int           ready_mode = 0;  // 0 tied high, 1 random delay, 2 hold hold_n cycles
  int           hold_n = 0;

  function automatic logic [127:0] init_line(input logic [31:0] a);
    if (a == 32'h0000_BB00) return 128'h3344;
    return {a, ~a, a ^ 32'hC0FF_EE00, 32'h600D_0000 | {16'h0, a[15:0]}};
  endfunction

  function automatic logic [127:0] mem_get(input bit model_side, input logic [31:0] a);
    if (model_side) return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
    return rsp_mem.exists(a) ? rsp_mem[a] : init_line(a);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 512; s++)
      for (int w = 0; w < 2; w++) begin
        m_val[s][w] = 1'b0; m_dirty[s][w] = 1'b0; m_stamp[s][w] = 0;
      end
    m_time = 0; m_hits = 0; m_miss = 0; m_wb = 0;
  endtask

  // Whole-request behaviour: true LRU over two ways, write-back, no fetch on write miss.
  task automatic model_access(input logic [31:0] addr, input logic rw,
                              input logic [127:0] wdata, input int acc);
    int s, hw, vw, phases;
    logic [18:0] tag;
    exp_t e;
    mexp_t m;
    s = int'(addr[12:4]);
    tag = addr[31:13];
    hw = -1; phases = 0;
    m_time++;
    for (int w = 0; w < 2; w++) if (m_val[s][w] && m_tag[s][w] == tag) hw = w;
    if (hw >= 0) begin
      m_hits++;
      if (rw) begin m_data[s][hw] = wdata; m_dirty[s][hw] = 1'b1; end
      m_stamp[s][hw] = m_time;
      e.data = m_data[s][hw];
    end else begin
      m_miss++;
      vw = -1;
      for (int w = 1; w >= 0; w--) if (!m_val[s][w]) vw = w;
      if (vw < 0) vw = (m_stamp[s][0] < m_stamp[s][1]) ? 0 : 1;
      if (m_val[s][vw] && m_dirty[s][vw]) begin
        m.rw = 1'b1; m.addr = {m_tag[s][vw], 9'(s), 4'h0}; m.data = m_data[s][vw];
        mexp_q.push_back(m);
        ref_mem[m.addr] = m.data;
        m_wb++; phases++;
      end
      if (rw) begin
        m_data[s][vw] = wdata; m_dirty[s][vw] = 1'b1;
      end else begin
        m.rw = 1'b0; m.addr = {addr[31:4], 4'h0}; m.data = '0;
        mexp_q.push_back(m);
        m_data[s][vw] = mem_get(1'b1, m.addr); m_dirty[s][vw] = 1'b0;
        phases += 2;  // refill phase plus the re-lookup
      end
      m_val[s][vw] = 1'b1; m_tag[s][vw] = tag; m_stamp[s][vw] = m_time;
      e.data = m_data[s][vw];
    end
    e.rw  = rw;
    e.acc = acc;
    e.lat = (ready_mode == 0) ? 1 + phases : -1;
`ifdef CACHE_STATS_EN
    e.hits = m_hits; e.miss = m_miss; e.wb = m_wb;
`else
    e.hits = 0; e.miss = 0; e.wb = 0;
`endif
    exp_q.push_back(e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int n = 0;
    while (!cache_ready && n < 300) begin @(negedge clock); n++; end
    total++;
    if (!cache_ready) begin bad++; $display("FAIL ready_timeout: cache_ready=0 after %0d cycles, required 1", n); end
  endtask

  task automatic issue(input logic [31:0] addr, input logic rw, input logic [127:0] data);
    wait_ready();
    model_access(addr, rw, data, cyc + 1);
    cpu_req_addr = addr; cpu_req_rw = rw; cpu_req_datain = data; cpu_req_valid = 1'b1;
    @(negedge clock);
    cpu_req_valid = 1'b0;
    // later input changes must not reach the latched request
    cpu_req_addr = $urandom; cpu_req_rw = 1'($urandom_range(0, 1));
    cpu_req_datain = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !cache_ready) && n < 2000) begin @(negedge clock); n++; end
    check("drain_exp_q", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_cache_ready", 128'(cache_ready), 128'd1);
    check("rst_resp_valid", 128'(cpu_resp_valid), 128'd0);
    check("rst_mem_valid", 128'(mem_req_valid), 128'd0);
    check("rst_mem_rw", 128'(mem_req_rw), 128'd0);
    check("rst_hit_count", 128'(hit_count), 128'd0);
    check("rst_miss_count", 128'(miss_count), 128'd0);
    check("rst_wb_count", 128'(wb_count), 128'd0);
  endtask

  // ---------------- memory responder / mem-side scoreboard ----------------
  initial begin : responder
    bit in_txn = 0, held = 0;
    int waited = 0, need = 0;
    logic [31:0] s_addr; logic s_rw; logic [127:0] s_data;
    mexp_t m;
    mem_req_ready = 1'b0; mem_req_datain = '0;
    forever begin
      @(negedge clock);
      if (!mem_req_valid || !reset_n) begin
        in_txn = 0; held = 0;
        mem_req_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end else begin
        check("busy_cache_ready", 128'(cache_ready), 128'd0);
        if (!in_txn) begin
          in_txn = 1; waited = 0;
          need = (ready_mode == 0) ? 0 : (ready_mode == 1) ? int'($urandom_range(0, 3)) : hold_n;
        end else if (held) begin
          check("stable_addr", 128'(mem_req_addr), 128'(s_addr));
          check("stable_rw", 128'(mem_req_rw), 128'(s_rw));
          check("stable_data", mem_req_dataout, s_data);
        end
        if (waited < need) begin
          mem_req_ready = 1'b0; waited++; held = 1;
          s_addr = mem_req_addr; s_rw = mem_req_rw; s_data = mem_req_dataout;
        end else begin
          mem_req_ready = 1'b1;
          mem_req_datain = mem_get(1'b0, mem_req_addr);
          total++;
          if (mexp_q.size() == 0) begin
            bad++;
            $display("FAIL mem_unexpected: rw=%0d addr=%h, required no memory request", mem_req_rw, mem_req_addr);
          end else begin
            m = mexp_q.pop_front();
            total--;
            check("mem_rw", 128'(mem_req_rw), 128'(m.rw));
            check("mem_addr", 128'(mem_req_addr), 128'(m.addr));
            if (m.rw) check("mem_wb_data", mem_req_dataout, m.data);
          end
          if (mem_req_rw) rsp_mem[mem_req_addr] = mem_req_dataout;
          in_txn = 0; held = 0;
        end
      end
    end
  end

  // ---------------- CPU response monitor ----------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_n && cpu_resp_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL resp_unexpected: dataout=%h, required no response", cpu_req_dataout);
        end else begin
          total--;
          e = exp_q.pop_front();
          if (!e.rw) check("read_data", cpu_req_dataout, e.data);
          if (e.lat >= 0) check("resp_latency", 128'(cyc - e.acc), 128'(e.lat));
          check("hit_count", 128'(hit_count), 128'(e.hits));
          check("miss_count", 128'(miss_count), 128'(e.miss));
          check("wb_count", 128'(wb_count), 128'(e.wb));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    int n;
    reset_n = 1'b0; cpu_req_valid = 1'b0; cpu_req_rw = 1'b0;
    cpu_req_addr = '0; cpu_req_datain = '0;
    model_reset();
    repeat (3) @(negedge clock);
    check_reset_outputs();
    check("rst_dataout", cpu_req_dataout, 128'd0);
    check("rst_mem_addr", 128'(mem_req_addr), 128'd0);
    check("rst_mem_dataout", mem_req_dataout, 128'd0);
    check("rst_state", 128'(dbg_state), 128'(IDLE));
    reset_n = 1'b1;
    @(negedge clock);

    // 1: cold write without memory traffic, then read back
    ready_mode = 0;
    issue(32'h0000_AB00, 1'b1, 128'h1122);
    issue(32'h0000_AB00, 1'b0, 128'h0);
    drain();

    // 2: cold read refills from memory
    issue(32'h0000_BB00, 1'b0, 128'h0);
    drain();

    // 3: three writes to one set evict the LRU dirty line
    issue(32'h0000_AB00, 1'b1, 128'h1122);
    issue(32'h0002_AB00, 1'b1, 128'h5566);
    issue(32'h0004_AB00, 1'b1, 128'h7788);
    issue(32'h0002_AB00, 1'b0, 128'h0);
    drain();

    // 4: write-back stalled by memory for 5 cycles
    ready_mode = 2; hold_n = 5;
    issue(32'h0006_AB00, 1'b1, 128'h99AA);
    drain();

    // 5: reset while refilling aborts the transaction
    hold_n = 1000;
    issue(32'h0008_BB00, 1'b0, 128'h0);
    n = 0;
    while (!(mem_req_valid && !mem_req_rw) && n < 50) begin @(negedge clock); n++; end
    check("alloc_reached", 128'(mem_req_valid && !mem_req_rw), 128'd1);
    reset_n = 1'b0;
    exp_q.delete(); mexp_q.delete(); model_reset();
    ready_mode = 0;
    @(negedge clock);
    check_reset_outputs();
    reset_n = 1'b1;
    @(negedge clock);
    issue(32'h0000_BB00, 1'b0, 128'h0);
    drain();

    // 6: requests pulsed while busy are dropped
    ready_mode = 2; hold_n = 6;
    issue(32'h0001_0B00, 1'b0, 128'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (!cache_ready) begin
        cpu_req_addr = 32'h0000_0300 | ($urandom_range(0, 7) << 13);
        cpu_req_rw = 1'($urandom_range(0, 1));
        cpu_req_valid = 1'b1;
        @(negedge clock);
        cpu_req_valid = 1'b0;
      end
    end
    drain();

    // randomized traffic over a few contended sets
    for (int i = 0; i < 200; i++) begin
      ready_mode = int'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       a = {13'(0), 19'h0};
        default: a = '0;
      endcase
      a[12:4] = ($urandom_range(0, 2) == 0) ? 9'h0B0 : ($urandom_range(0, 1) ? 9'h003 : 9'h1FF);
      a[31:13] = 19'($urandom_range(0, 4));
      a[3:0] = 4'($urandom_range(0, 15));
      issue(a, 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom});
      if (ready_mode == 0) drain();
    end
    drain();
    check("final_exp_q_empty", 128'(exp_q.size()), 128'd0);
    check("final_mexp_q_empty", 128'(mexp_q.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
